// File: rtl/npc_lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : npc_lsu_pkg
// Description : Shared types and constants for the NPC load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
package npc_lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } sz_e;

    typedef enum logic [1:0] {
        L_IDLE = 2'd0,
        L_AR   = 2'd1,
        L_R    = 2'd2
    } load_state_e;

    typedef enum logic [1:0] {
        D_IDLE = 2'd0,
        D_ADDR = 2'd1,
        D_RESP = 2'd2
    } drain_state_e;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

endpackage
`default_nettype wire

// File: rtl/lsu_store_buf.sv
`default_nettype none
// ============================================================================
// Module      : lsu_store_buf
// Description : FIFO of bus-aligned store entries with an address-hit probe.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_store_buf
    import npc_lsu_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int BUS_W  = 64,
    parameter int DEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic [ADDR_W-1:0]    push_addr,
    input  logic [BUS_W-1:0]     push_data,
    input  logic [BUS_W/8-1:0]   push_strb,
    input  logic                 pop,
    output logic [ADDR_W-1:0]    head_addr,
    output logic [BUS_W-1:0]     head_data,
    output logic [BUS_W/8-1:0]   head_strb,
    output logic                 full,
    output logic                 empty,
    input  logic [ADDR_W-1:0]    hit_addr,
    output logic                 addr_hit
);

    localparam int c_idx_w  = $clog2(DEPTH);
    localparam int c_strb_w = BUS_W / 8;

    logic [ADDR_W-1:0]   r_addr [DEPTH];
    logic [BUS_W-1:0]    r_data [DEPTH];
    logic [c_strb_w-1:0] r_strb [DEPTH];
    logic [DEPTH-1:0]    r_vld;
    logic [c_idx_w:0]    r_wr_ptr;
    logic [c_idx_w:0]    r_rd_ptr;

    logic [c_idx_w-1:0]  w_wr_idx;
    logic [c_idx_w-1:0]  w_rd_idx;
    logic [DEPTH-1:0]    w_hit_vec;
    logic                w_do_push;
    logic                w_do_pop;

    assign w_wr_idx  = r_wr_ptr[c_idx_w-1:0];
    assign w_rd_idx  = r_rd_ptr[c_idx_w-1:0];
    assign full      = (w_wr_idx == w_rd_idx) && (r_wr_ptr[c_idx_w] != r_rd_ptr[c_idx_w]);
    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    assign head_addr = r_addr[w_rd_idx];
    assign head_data = r_data[w_rd_idx];
    assign head_strb = r_strb[w_rd_idx];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_addr[w_wr_idx] <= push_addr;
            r_data[w_wr_idx] <= push_data;
            r_strb[w_wr_idx] <= push_strb;
        end
    end

    // Push and pop never target the same slot: a pop needs a non-empty
    // buffer and a push a non-full one, so the indices differ.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_vld    <= '0;
        end else begin
            if (w_do_push) begin
                r_vld[w_wr_idx] <= 1'b1;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_vld[w_rd_idx] <= 1'b0;
                r_rd_ptr        <= r_rd_ptr + 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
            assign w_hit_vec[gi] = r_vld[gi] && (r_addr[gi] == hit_addr);
        end
    endgenerate

    assign addr_hit = |w_hit_vec;

endmodule
`default_nettype wire

// File: rtl/lsu_axi.sv
`default_nettype none
// ============================================================================
// Module      : lsu_axi
// Description : Load/store unit with store buffer onto an AXI4-Lite-style bus.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_axi
    import npc_lsu_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter int ADDR_W   = 64,
    parameter int BUS_W    = 64,
    parameter int SB_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_store,
    input  logic [1:0]           req_size,
    input  logic                 req_unsigned,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [XLEN-1:0]      req_wdata,
    output logic                 resp_valid,
    output logic [XLEN-1:0]      resp_data,
    output logic                 resp_err,
    output logic                 store_err,
    output logic                 sb_empty,
    output logic [ADDR_W-1:0]    aw_addr,
    output logic                 aw_valid,
    input  logic                 aw_ready,
    output logic [BUS_W-1:0]     w_data,
    output logic [BUS_W/8-1:0]   w_strb,
    output logic                 w_valid,
    input  logic                 w_ready,
    input  logic                 b_valid,
    input  logic [1:0]           b_resp,
    output logic                 b_ready,
    output logic [ADDR_W-1:0]    ar_addr,
    output logic                 ar_valid,
    input  logic                 ar_ready,
    input  logic [BUS_W-1:0]     r_data,
    input  logic [1:0]           r_resp,
    input  logic                 r_valid,
    output logic                 r_ready
);

    localparam int c_strb_w = BUS_W / 8;
    localparam int c_off_w  = $clog2(c_strb_w);

    // Request decode
    logic [c_off_w-1:0]  w_off;
    logic [ADDR_W-1:0]   w_bus_addr;
    sz_e                 w_size;
    logic                w_misalign;
    logic                w_illegal;
    logic [c_strb_w-1:0] w_byte_en;
    logic [c_strb_w-1:0] w_push_strb;
    logic [BUS_W-1:0]    w_push_data;
    logic                w_accept;
    logic                w_push;
    logic                w_load_go;

    // Store buffer
    logic                w_full;
    logic                w_empty;
    logic                w_hit;
    logic                w_pop;
    logic [ADDR_W-1:0]   w_head_addr;
    logic [BUS_W-1:0]    w_head_data;
    logic [c_strb_w-1:0] w_head_strb;

    // Load path
    load_state_e         r_l_state;
    logic [c_off_w-1:0]  r_l_off;
    sz_e                 r_l_size;
    logic                r_l_unsigned;
    logic [ADDR_W-1:0]   r_ar_addr;
    logic                r_ar_valid;
    logic                r_r_ready;
    logic [BUS_W-1:0]    w_r_shift;
    logic [XLEN-1:0]     w_ld_ext;
    logic                r_resp_valid;
    logic [XLEN-1:0]     r_resp_data;
    logic                r_resp_err;

    // Drain path
    drain_state_e        r_d_state;
    logic                r_aw_valid;
    logic                r_w_valid;
    logic                r_b_ready;
    logic                r_store_err;
    logic                w_aw_done;
    logic                w_w_done;

    assign w_off      = req_addr[c_off_w-1:0];
    assign w_bus_addr = {req_addr[ADDR_W-1:c_off_w], {c_off_w{1'b0}}};
    assign w_size     = sz_e'(req_size);

    always_comb begin
        w_misalign = 1'b0;
        w_byte_en  = '0;
        case (w_size)
            SZ_B: begin
                w_byte_en  = c_strb_w'(8'h01);
            end
            SZ_H: begin
                w_misalign = req_addr[0];
                w_byte_en  = c_strb_w'(8'h03);
            end
            SZ_W: begin
                w_misalign = |req_addr[1:0];
                w_byte_en  = c_strb_w'(8'h0F);
            end
            default: begin
                w_misalign = |req_addr[2:0];
                w_byte_en  = c_strb_w'(8'hFF);
            end
        endcase
    end

    assign w_illegal   = w_misalign || ((w_size == SZ_D) && (XLEN == 32));
    assign w_push_strb = w_byte_en << w_off;
    assign w_push_data = BUS_W'(req_wdata) << {w_off, 3'b000};

    // Stores only wait for space; loads also wait out any buffered write
    // to the same bus word, which keeps read/write overlap on the bus safe.
    assign req_ready = (r_l_state == L_IDLE) && (req_store ? !w_full : !w_hit);
    assign w_accept  = req_valid && req_ready;
    assign w_push    = w_accept && req_store && !w_illegal;
    assign w_load_go = w_accept && !req_store && !w_illegal;
    assign w_pop     = (r_d_state == D_RESP) && b_valid;

    lsu_store_buf #(
        .ADDR_W (ADDR_W),
        .BUS_W  (BUS_W),
        .DEPTH  (SB_DEPTH)
    ) u_store_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .push_addr (w_bus_addr),
        .push_data (w_push_data),
        .push_strb (w_push_strb),
        .pop       (w_pop),
        .head_addr (w_head_addr),
        .head_data (w_head_data),
        .head_strb (w_head_strb),
        .full      (w_full),
        .empty     (w_empty),
        .hit_addr  (w_bus_addr),
        .addr_hit  (w_hit)
    );

    assign w_r_shift = r_data >> {r_l_off, 3'b000};

    always_comb begin
        w_ld_ext = w_r_shift[XLEN-1:0];
        case (r_l_size)
            SZ_B: w_ld_ext = r_l_unsigned ? XLEN'(w_r_shift[7:0])
                                          : XLEN'($signed(w_r_shift[7:0]));
            SZ_H: w_ld_ext = r_l_unsigned ? XLEN'(w_r_shift[15:0])
                                          : XLEN'($signed(w_r_shift[15:0]));
            SZ_W: w_ld_ext = r_l_unsigned ? XLEN'(w_r_shift[31:0])
                                          : XLEN'($signed(w_r_shift[31:0]));
            default: w_ld_ext = w_r_shift[XLEN-1:0];
        endcase
    end

    // Load FSM plus the response register. Requests are only accepted in
    // L_IDLE, so a store/illegal response never collides with a load one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_l_state    <= L_IDLE;
            r_l_off      <= '0;
            r_l_size     <= SZ_B;
            r_l_unsigned <= 1'b0;
            r_ar_addr    <= '0;
            r_ar_valid   <= 1'b0;
            r_r_ready    <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_resp_err   <= 1'b0;
            if (w_accept && (w_illegal || req_store)) begin
                r_resp_valid <= 1'b1;
                r_resp_err   <= w_illegal;
            end
            case (r_l_state)
                L_IDLE: begin
                    if (w_load_go) begin
                        r_l_off      <= w_off;
                        r_l_size     <= w_size;
                        r_l_unsigned <= req_unsigned;
                        r_ar_addr    <= w_bus_addr;
                        r_ar_valid   <= 1'b1;
                        r_l_state    <= L_AR;
                    end
                end
                L_AR: begin
                    if (ar_ready) begin
                        r_ar_valid <= 1'b0;
                        r_r_ready  <= 1'b1;
                        r_l_state  <= L_R;
                    end
                end
                L_R: begin
                    if (r_valid) begin
                        r_r_ready    <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= (r_resp != AXI_RESP_OKAY);
                        r_resp_data  <= (r_resp != AXI_RESP_OKAY) ? '0 : w_ld_ext;
                        r_l_state    <= L_IDLE;
                    end
                end
                default: r_l_state <= L_IDLE;
            endcase
        end
    end

    assign w_aw_done = !r_aw_valid || aw_ready;
    assign w_w_done  = !r_w_valid || w_ready;

    // Drain FSM: the head entry stays in the buffer until its B response,
    // so it keeps participating in the load hazard check while in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_d_state   <= D_IDLE;
            r_aw_valid  <= 1'b0;
            r_w_valid   <= 1'b0;
            r_b_ready   <= 1'b0;
            r_store_err <= 1'b0;
        end else begin
            case (r_d_state)
                D_IDLE: begin
                    if (!w_empty) begin
                        r_aw_valid <= 1'b1;
                        r_w_valid  <= 1'b1;
                        r_d_state  <= D_ADDR;
                    end
                end
                D_ADDR: begin
                    if (aw_ready) r_aw_valid <= 1'b0;
                    if (w_ready)  r_w_valid  <= 1'b0;
                    if (w_aw_done && w_w_done) begin
                        r_b_ready <= 1'b1;
                        r_d_state <= D_RESP;
                    end
                end
                D_RESP: begin
                    if (b_valid) begin
                        r_b_ready <= 1'b0;
                        if (b_resp != AXI_RESP_OKAY) r_store_err <= 1'b1;
                        r_d_state <= D_IDLE;
                    end
                end
                default: r_d_state <= D_IDLE;
            endcase
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;
    assign resp_err   = r_resp_err;
    assign store_err  = r_store_err;
    assign sb_empty   = w_empty && (r_d_state == D_IDLE);
    assign aw_valid   = r_aw_valid;
    assign aw_addr    = r_aw_valid ? w_head_addr : '0;
    assign w_valid    = r_w_valid;
    assign w_data     = r_w_valid ? w_head_data : '0;
    assign w_strb     = r_w_valid ? w_head_strb : '0;
    assign b_ready    = r_b_ready;
    assign ar_valid   = r_ar_valid;
    assign ar_addr    = r_ar_addr;
    assign r_ready    = r_r_ready;

endmodule
`default_nettype wire

// File: tb/tb_lsu_axi.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_axi
// Description : Directed self-checking bench for lsu_axi.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_axi;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_store, req_unsigned;
    logic [1:0]  req_size;
    logic [63:0] req_addr, req_wdata;
    logic        resp_valid, resp_err, store_err, sb_empty;
    logic [63:0] resp_data;
    logic [63:0] aw_addr, ar_addr, w_data, r_data;
    logic [7:0]  w_strb;
    logic        aw_valid, aw_ready, w_valid, w_ready;
    logic        b_valid, b_ready, ar_valid, ar_ready, r_valid, r_ready;
    logic [1:0]  b_resp, r_resp;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lsu_axi #(.XLEN(64), .ADDR_W(64), .BUS_W(64), .SB_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_data(resp_data),
        .resp_err(resp_err), .store_err(store_err), .sb_empty(sb_empty),
        .aw_addr(aw_addr), .aw_valid(aw_valid), .aw_ready(aw_ready),
        .w_data(w_data), .w_strb(w_strb), .w_valid(w_valid), .w_ready(w_ready),
        .b_valid(b_valid), .b_resp(b_resp), .b_ready(b_ready),
        .ar_addr(ar_addr), .ar_valid(ar_valid), .ar_ready(ar_ready),
        .r_data(r_data), .r_resp(r_resp), .r_valid(r_valid), .r_ready(r_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request and hold it until accepted; returns one step after the accepting edge.
    task automatic issue(input logic st, input logic [1:0] sz, input logic uns,
                         input logic [63:0] addr, input logic [63:0] wd);
        int n;
        req_store = st; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd; req_valid = 1'b1;
        #1;
        n = 0;
        while (!req_ready && n < 50) begin tick(); n++; end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL issue_accept: req_ready=%b after %0d cycles, required 1", req_ready, n);
            req_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            req_valid = 1'b0;
        end
    endtask

    // Act as the write slave for the head entry and check its payload.
    task automatic drain_one(input logic [63:0] ea, input logic [63:0] ed, input logic [7:0] es,
                             input logic [1:0] br, input logic chk_full);
        int n;
        n = 0;
        while (!aw_valid && n < 50) begin tick(); n++; end
        checks++;
        if (aw_addr !== ea) begin errors++; $display("FAIL drain_aw_addr: got %h required %h", aw_addr, ea); end
        checks++;
        if (w_data !== ed) begin errors++; $display("FAIL drain_w_data: got %h required %h", w_data, ed); end
        checks++;
        if (w_strb !== es) begin errors++; $display("FAIL drain_w_strb: got %h required %h", w_strb, es); end
        aw_ready = 1'b1; w_ready = 1'b1;
        tick();
        aw_ready = 1'b0; w_ready = 1'b0;
        n = 0;
        while (!b_ready && n < 50) begin tick(); n++; end
        b_valid = 1'b1; b_resp = br;
        if (chk_full) begin
            #1;
            checks++;
            if (req_ready !== 1'b0) begin errors++; $display("FAIL full_pop_same_cycle: req_ready=%b required 0", req_ready); end
        end
        tick();
        b_valid = 1'b0; b_resp = 2'b00;
    endtask

    // Act as the read slave: take AR, return one R beat.
    task automatic read_resp(input logic [63:0] rd, input logic [1:0] rr);
        int n;
        n = 0;
        while (!ar_valid && n < 50) begin tick(); n++; end
        ar_ready = 1'b1;
        tick();
        ar_ready = 1'b0;
        n = 0;
        while (!r_ready && n < 50) begin tick(); n++; end
        r_valid = 1'b1; r_data = rd; r_resp = rr;
        tick();
        r_valid = 1'b0; r_data = '0; r_resp = 2'b00;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b required 1", req_ready); end
        checks++; if (sb_empty !== 1'b1) begin errors++; $display("FAIL reset_sb_empty: got %b required 1", sb_empty); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b required 0", resp_valid); end
        checks++; if ({aw_valid, w_valid, ar_valid, b_ready, r_ready} !== 5'b0) begin
            errors++; $display("FAIL reset_bus_valids: got %b required 00000", {aw_valid, w_valid, ar_valid, b_ready, r_ready}); end
        checks++; if (store_err !== 1'b0) begin errors++; $display("FAIL reset_store_err: got %b required 0", store_err); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_store_byte();
        issue(1'b1, 2'd0, 1'b0, 64'h8000_0005, 64'hAB);
        checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b0) begin
            errors++; $display("FAIL sb_resp: valid=%b err=%b required 1/0", resp_valid, resp_err); end
        checks++; if (aw_valid !== 1'b0) begin errors++; $display("FAIL sb_aw_early: aw_valid=%b required 0 at T+1", aw_valid); end
        tick();
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL sb_resp_pulse: resp_valid=%b required 0", resp_valid); end
        checks++; if (aw_valid !== 1'b1 || w_valid !== 1'b1) begin
            errors++; $display("FAIL sb_aw_w_valid: aw=%b w=%b required 1/1 at T+2", aw_valid, w_valid); end
        drain_one(64'h8000_0000, 64'h0000_AB00_0000_0000, 8'h20, 2'b00, 1'b0);
        checks++; if (sb_empty !== 1'b1) begin errors++; $display("FAIL sb_drained: sb_empty=%b required 1", sb_empty); end
    endtask

    task automatic test_load_byte();
        issue(1'b0, 2'd0, 1'b0, 64'h8000_0003, 64'h0);
        checks++; if (ar_valid !== 1'b1) begin errors++; $display("FAIL lb_ar_valid: got %b required 1", ar_valid); end
        checks++; if (ar_addr !== 64'h8000_0000) begin errors++; $display("FAIL lb_ar_addr: got %h required 80000000", ar_addr); end
        read_resp(64'h0000_0000_8000_0000, 2'b00);
        checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b0) begin
            errors++; $display("FAIL lb_resp: valid=%b err=%b required 1/0", resp_valid, resp_err); end
        checks++; if (resp_data !== 64'hFFFF_FFFF_FFFF_FF80) begin
            errors++; $display("FAIL lb_signed: got %h required ffffffffffffff80", resp_data); end
        tick();
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL lb_resp_pulse: got %b required 0", resp_valid); end
        issue(1'b0, 2'd0, 1'b1, 64'h8000_0003, 64'h0);
        read_resp(64'h0000_0000_8000_0000, 2'b00);
        checks++; if (resp_data !== 64'h80) begin errors++; $display("FAIL lbu_unsigned: got %h required 80", resp_data); end
        issue(1'b0, 2'd1, 1'b0, 64'h8000_0006, 64'h0);
        read_resp(64'h8765_4321_0000_0000, 2'b00);
        checks++; if (resp_data !== 64'hFFFF_FFFF_FFFF_8765) begin
            errors++; $display("FAIL lh_signed: got %h required ffffffffffff8765", resp_data); end
    endtask

    task automatic test_misaligned();
        issue(1'b0, 2'd2, 1'b0, 64'h8000_0002, 64'h0);
        checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b1) begin
            errors++; $display("FAIL mis_lw_resp: valid=%b err=%b required 1/1", resp_valid, resp_err); end
        checks++; if (resp_data !== 64'h0) begin errors++; $display("FAIL mis_lw_data: got %h required 0", resp_data); end
        checks++; if (ar_valid !== 1'b0 || aw_valid !== 1'b0) begin
            errors++; $display("FAIL mis_lw_bus: ar=%b aw=%b required 0/0", ar_valid, aw_valid); end
        issue(1'b1, 2'd1, 1'b0, 64'h8000_0001, 64'h1234);
        checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b1) begin
            errors++; $display("FAIL mis_sh_resp: valid=%b err=%b required 1/1", resp_valid, resp_err); end
        tick();
        checks++; if (aw_valid !== 1'b0 || sb_empty !== 1'b1 || ar_valid !== 1'b0) begin
            errors++; $display("FAIL mis_sh_bus: aw=%b sb_empty=%b ar=%b required 0/1/0", aw_valid, sb_empty, ar_valid); end
    endtask

    task automatic test_buffer_full();
        logic [63:0] base, dat;
        base = 64'h8000_1000;
        dat  = 64'h1111_2222_3333_0000;
        for (int i = 0; i < 4; i++) issue(1'b1, 2'd3, 1'b0, base + 64'(8 * i), dat + 64'(i));
        req_store = 1'b1; req_size = 2'd3; req_addr = base + 64'd32; req_wdata = dat + 64'd4;
        req_valid = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b required 0", req_ready); end
        drain_one(base, dat, 8'hFF, 2'b00, 1'b1);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL ready_after_pop: got %b required 1", req_ready); end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int i = 1; i < 5; i++) drain_one(base + 64'(8 * i), dat + 64'(i), 8'hFF, 2'b00, 1'b0);
        for (int i = 5; i < 9; i++) issue(1'b1, 2'd3, 1'b0, base + 64'(8 * i), dat + 64'(i));
        for (int i = 5; i < 9; i++) drain_one(base + 64'(8 * i), dat + 64'(i), 8'hFF, 2'b00, 1'b0);
        issue(1'b1, 2'd3, 1'b0, base + 64'd72, dat + 64'd9);
        drain_one(base + 64'd72, dat + 64'd9, 8'hFF, 2'b00, 1'b0);
        checks++; if (sb_empty !== 1'b1) begin errors++; $display("FAIL wrap_empty: sb_empty=%b required 1", sb_empty); end
    endtask

    task automatic test_load_hazard();
        issue(1'b1, 2'd3, 1'b0, 64'h8000_0010, 64'hCAFE_F00D_1234_5678);
        tick();
        req_store = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 64'h8000_0014;
        req_valid = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL hazard_block: req_ready=%b required 0", req_ready); end
        req_size = 2'd3; req_addr = 64'h8000_0020;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL no_hazard_ready: req_ready=%b required 1", req_ready); end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        checks++; if (ar_addr !== 64'h8000_0020) begin errors++; $display("FAIL no_hazard_ar_addr: got %h required 80000020", ar_addr); end
        read_resp(64'h0123_4567_89AB_CDEF, 2'b00);
        checks++; if (resp_data !== 64'h0123_4567_89AB_CDEF) begin
            errors++; $display("FAIL ld_overlap_data: got %h required 0123456789abcdef", resp_data); end
        req_size = 2'd2; req_addr = 64'h8000_0014; req_valid = 1'b1;
        repeat (3) tick();
        checks++; if (ar_valid !== 1'b0) begin errors++; $display("FAIL hazard_stall_ar: ar_valid=%b required 0", ar_valid); end
        aw_ready = 1'b1; w_ready = 1'b1;
        tick();
        aw_ready = 1'b0; w_ready = 1'b0;
        checks++; if (b_ready !== 1'b1 || req_ready !== 1'b0) begin
            errors++; $display("FAIL hazard_during_b: b_ready=%b req_ready=%b required 1/0", b_ready, req_ready); end
        b_valid = 1'b1;
        tick();
        b_valid = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        checks++; if (ar_valid !== 1'b1 || ar_addr !== 64'h8000_0010) begin
            errors++; $display("FAIL hazard_release_ar: valid=%b addr=%h required 1/80000010", ar_valid, ar_addr); end
        read_resp(64'hDEAD_BEEF_0000_0000, 2'b00);
        checks++; if (resp_data !== 64'hFFFF_FFFF_DEAD_BEEF) begin
            errors++; $display("FAIL hazard_lw_data: got %h required ffffffffdeadbeef", resp_data); end
    endtask

    task automatic test_bus_errors();
        issue(1'b1, 2'd3, 1'b0, 64'h8000_0040, 64'h55);
        drain_one(64'h8000_0040, 64'h55, 8'hFF, 2'b10, 1'b0);
        checks++; if (store_err !== 1'b1) begin errors++; $display("FAIL store_err_set: got %b required 1", store_err); end
        issue(1'b1, 2'd2, 1'b0, 64'h8000_0044, 64'hAABB_CCDD);
        drain_one(64'h8000_0040, 64'hAABB_CCDD_0000_0000, 8'hF0, 2'b00, 1'b0);
        checks++; if (store_err !== 1'b1) begin errors++; $display("FAIL store_err_sticky: got %b required 1", store_err); end
        issue(1'b0, 2'd3, 1'b0, 64'h8000_0048, 64'h0);
        read_resp(64'h1234, 2'b10);
        checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_data !== 64'h0) begin
            errors++; $display("FAIL load_bus_err: valid=%b err=%b data=%h required 1/1/0", resp_valid, resp_err, resp_data); end
    endtask

    task automatic test_reset_mid();
        issue(1'b1, 2'd0, 1'b0, 64'h8000_0061, 64'h7E);
        issue(1'b0, 2'd3, 1'b0, 64'h8000_0080, 64'h0);
        ar_ready = 1'b1;
        tick();
        ar_ready = 1'b0;
        checks++; if (r_ready !== 1'b1 || aw_valid !== 1'b1) begin
            errors++; $display("FAIL pre_reset_state: r_ready=%b aw_valid=%b required 1/1", r_ready, aw_valid); end
        rst_n = 1'b0;
        tick();
        checks++; if ({aw_valid, w_valid, b_ready, ar_valid, r_ready, resp_valid} !== 6'b0) begin
            errors++; $display("FAIL mid_reset_valids: got %b required 000000", {aw_valid, w_valid, b_ready, ar_valid, r_ready, resp_valid}); end
        checks++; if (req_ready !== 1'b1 || sb_empty !== 1'b1 || store_err !== 1'b0) begin
            errors++; $display("FAIL mid_reset_status: ready=%b empty=%b store_err=%b required 1/1/0", req_ready, sb_empty, store_err); end
        checks++; if (aw_addr !== 64'h0 || w_strb !== 8'h0 || ar_addr !== 64'h0 || resp_data !== 64'h0) begin
            errors++; $display("FAIL mid_reset_payload: aw=%h strb=%h ar=%h data=%h required 0", aw_addr, w_strb, ar_addr, resp_data); end
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required bench completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0; aw_ready = 1'b0; w_ready = 1'b0; b_valid = 1'b0;
        b_resp = 2'b00; ar_ready = 1'b0; r_valid = 1'b0; r_data = '0; r_resp = 2'b00;
        test_reset();
        test_store_byte();
        test_load_byte();
        test_misaligned();
        test_buffer_full();
        test_load_hazard();
        test_bus_errors();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
